// File: rtl/pc_predict_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator and its BTB.
// Counter encoding is the usual 2-bit saturating predictor; MSB set means "predict taken".
package pc_predict_gen_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Fresh allocations start weakly taken so one not-taken outcome flips them.
    localparam ctr_t CTR_ALLOC = WT;

    function automatic ctr_t ctr_inc(input ctr_t c);
        ctr_t r;
        case (c)
            SNT:     r = WNT;
            WNT:     r = WT;
            default: r = ST;
        endcase
        return r;
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        ctr_t r;
        case (c)
            ST:      r = WT;
            WT:      r = WNT;
            default: r = SNT;
        endcase
        return r;
    endfunction

    function automatic logic ctr_taken(input ctr_t c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/pc_predict_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup for the fetch PC,
// clocked update from the execute stage (no write-to-read bypass).
module btb
    import pc_predict_gen_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:2] lkp_addr,
    output logic            hit_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd,
    input  logic [XLEN-1:2] upd_addr,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int unsigned IDX  = $clog2(DEPTH);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic [DEPTH-1:0] valid_q;
    logic [TAGW-1:0]  tag_q [DEPTH];
    logic [XLEN-1:0]  tgt_q [DEPTH];
    ctr_t             ctr_q [DEPTH];

    logic [IDX-1:0]  lkp_idx;
    logic [TAGW-1:0] lkp_tag;
    logic            lkp_hit;
    logic [IDX-1:0]  upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;

    assign lkp_idx = lkp_addr[IDX+1:2];
    assign lkp_tag = lkp_addr[XLEN-1:IDX+2];
    assign upd_idx = upd_addr[IDX+1:2];
    assign upd_tag = upd_addr[XLEN-1:IDX+2];

    always_comb begin
        lkp_hit     = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
        hit_taken   = lkp_hit && ctr_taken(ctr_q[lkp_idx]);
        pred_target = hit_taken ? tgt_q[lkp_idx] : '0;
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd && !upd_hit && upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Payload fields carry no reset; entries are qualified by valid_q alone.
    always_ff @(posedge clk) begin
        if (upd && !rst) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_q[upd_idx] <= ctr_inc(ctr_q[upd_idx]);
                    tgt_q[upd_idx] <= upd_target;
                end else begin
                    ctr_q[upd_idx] <= ctr_dec(ctr_q[upd_idx]);
                end
            end else if (upd_taken) begin
                tag_q[upd_idx] <= upd_tag;
                tgt_q[upd_idx] <= upd_target;
                ctr_q[upd_idx] <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: rtl/pc_predict_gen.sv
// Fetch-stage next-PC generator: redirect > stall > BTB prediction > sequential PC+4.
module pc_predict_gen
    import pc_predict_gen_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned     BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            UpdE,
    input  logic [XLEN-1:0] UpdPCE,
    input  logic [XLEN-1:0] UpdTargetE,
    input  logic            UpdTakenE,
    output logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    logic [XLEN-1:0] pc_next;
    logic            unused_upd_lsb;

    // Instructions are word-aligned for indexing purposes; the low bits never reach the BTB.
    assign unused_upd_lsb = ^UpdPCE[1:0];

    btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lkp_addr    (PCF[XLEN-1:2]),
        .hit_taken   (PredTakenF),
        .pred_target (PredTargetF),
        .upd         (UpdE),
        .upd_addr    (UpdPCE[XLEN-1:2]),
        .upd_target  (UpdTargetE),
        .upd_taken   (UpdTakenE)
    );

    always_comb begin
        pc_next = PCF + PC_INC;
        if (PCSrcE) begin
            pc_next = PCTargetE;
        end else if (StallF) begin
            pc_next = PCF;
        end else if (PredTakenF) begin
            pc_next = PredTargetF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF <= RESET_VEC;
        end else begin
            PCF <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_predict_gen.sv
// Directed bench for pc_predict_gen: reset, BTB allocate/train/replace, stall/redirect priority, wrap.
module tb_pc_predict_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        UpdE;
    logic [31:0] UpdPCE;
    logic [31:0] UpdTargetE;
    logic        UpdTakenE;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pc_predict_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .BTB_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .UpdE        (UpdE),
        .UpdPCE      (UpdPCE),
        .UpdTargetE  (UpdTargetE),
        .UpdTakenE   (UpdTakenE),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        PCSrcE    = 1'b1;
        PCTargetE = target;
        tick();
        PCSrcE    = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        UpdE       = 1'b1;
        UpdPCE     = pc;
        UpdTargetE = tgt;
        UpdTakenE  = taken;
        tick();
        UpdE       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        UpdE = 1'b0; UpdPCE = '0; UpdTargetE = '0; UpdTakenE = 1'b0;
        #2;
        check("reset_pcf", PCF, 32'h0);
        check("reset_predtaken", {31'b0, PredTakenF}, 32'h0);
        check("reset_predtarget", PredTargetF, 32'h0);
        tick(); tick();
        check("reset_hold", PCF, 32'h0);
        rst = 1'b0;
        tick();
        check("release_first", PCF, 32'h4);
        tick();
        check("release_second", PCF, 32'h8);

        // Scenario 1: reset mid-run from 0x40, with a concurrent redirect and update.
        redirect(32'h40);
        check("redir_0x40", PCF, 32'h40);
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        UpdE = 1'b1; UpdPCE = 32'h44; UpdTargetE = 32'h99; UpdTakenE = 1'b1;
        rst = 1'b1;
        #1;
        check("async_reset", PCF, 32'h0);
        tick();
        check("reset_discards_redirect", PCF, 32'h0);
        rst = 1'b0; PCSrcE = 1'b0; UpdE = 1'b0;
        tick();
        check("s1_after_release_4", PCF, 32'h4);
        tick();
        check("s1_after_release_8", PCF, 32'h8);
        redirect(32'h44);
        check("reset_discards_update", {31'b0, PredTakenF}, 32'h0);

        // Scenario 2: hold at 0x10, allocate it; the write is not visible until the edge.
        StallF = 1'b1;
        redirect(32'h10);
        check("s2_at_0x10", PCF, 32'h10);
        UpdE = 1'b1; UpdPCE = 32'h10; UpdTargetE = 32'h80; UpdTakenE = 1'b1;
        #1;
        check("s2_no_bypass", {31'b0, PredTakenF}, 32'h0);
        tick();
        UpdE = 1'b0;
        check("s2_stall_hold", PCF, 32'h10);
        check("s2_predtaken", {31'b0, PredTakenF}, 32'h1);
        check("s2_predtarget", PredTargetF, 32'h80);
        StallF = 1'b0;
        tick();
        check("s2_follow_pred", PCF, 32'h80);

        // Scenario 3: two not-taken outcomes drive 10 -> 01 -> 00.
        update(32'h10, 32'h0, 1'b0);
        update(32'h10, 32'h0, 1'b0);
        redirect(32'h10);
        check("s3_predtaken", {31'b0, PredTakenF}, 32'h0);
        check("s3_predtarget", PredTargetF, 32'h0);
        tick();
        check("s3_seq", PCF, 32'h14);
        // 00 -> 01 still not taken, 01 -> 10 taken with the refreshed target.
        update(32'h10, 32'h90, 1'b1);
        redirect(32'h10);
        check("s3_wnt", {31'b0, PredTakenF}, 32'h0);
        update(32'h10, 32'h90, 1'b1);
        redirect(32'h10);
        check("s3_retrain_taken", {31'b0, PredTakenF}, 32'h1);
        check("s3_retrain_target", PredTargetF, 32'h90);

        // Scenario 4: redirect wins over stall; unaligned targets pass through.
        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
        tick();
        PCSrcE = 1'b0;
        check("s4_redirect_over_stall", PCF, 32'h200);
        tick();
        check("s4_stall", PCF, 32'h200);
        StallF = 1'b0;
        tick();
        check("s4_resume", PCF, 32'h204);
        redirect(32'h203);
        check("s4_unaligned", PCF, 32'h203);
        tick();
        check("s4_unaligned_inc", PCF, 32'h207);

        // Scenario 5: 0x50 evicts 0x10 at index 4; a not-taken miss writes nothing.
        update(32'h50, 32'hA0, 1'b1);
        redirect(32'h10);
        check("s5_evicted", {31'b0, PredTakenF}, 32'h0);
        tick();
        check("s5_evicted_seq", PCF, 32'h14);
        update(32'h10, 32'hCC, 1'b0);
        redirect(32'h50);
        check("s5_new_taken", {31'b0, PredTakenF}, 32'h1);
        check("s5_new_target", PredTargetF, 32'hA0);
        tick();
        check("s5_follow", PCF, 32'hA0);

        // Scenario 6: sequential increment wraps at the top of the address space.
        redirect(32'hFFFF_FFFC);
        check("s6_no_hit", {31'b0, PredTakenF}, 32'h0);
        tick();
        check("s6_wrap", PCF, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_predict_gen.md
PC_PREDICT_GEN -- requirements
Module: pc_predict_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the PCF value loaded on reset.
REQ-003 SHALL have parameter BTB_DEPTH, default 16, meaning the number of BTB entries; it is a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port StallF, input, 1; when high, PCF holds its value.
REQ-007 SHALL have port PCSrcE, input, 1; when high, execute-stage redirect (mispredict or jump) to PCTargetE.
REQ-008 SHALL have port PCTargetE, input, XLEN, the redirect address.
REQ-009 SHALL have port UpdE, input, 1; when high, a resolved control-flow instruction updates the BTB.
REQ-010 SHALL have port UpdPCE, input, XLEN, the address of the resolved instruction.
REQ-011 SHALL have port UpdTargetE, input, XLEN, the resolved target.
REQ-012 SHALL have port UpdTakenE, input, 1, the resolved direction.
REQ-013 SHALL have port PCF, output, XLEN, the current fetch address (registered).
REQ-014 SHALL have port PredTakenF, output, 1, the prediction for PCF (combinational from PCF and BTB state).
REQ-015 SHALL have port PredTargetF, output, XLEN, the predicted target; it is 0 when PredTakenF=0.

Function
REQ-016 SHALL implement a direct-mapped BTB with IDX=log2(BTB_DEPTH) and index = address bits [IDX+1:2].
- Tag = address bits [XLEN-1:IDX+2].
- Each entry holds: valid, tag, target (XLEN), 2-bit saturating counter.
REQ-017 SHALL define lookup hit as: entry[PCF index] valid and tags equal; PredTakenF = hit AND counter[1].
REQ-018 SHALL compute the next PC with strict priority: PCSrcE -> PCTargetE; else StallF -> PCF; else PredTakenF -> PredTargetF; else PCF+4.
REQ-019 SHALL override StallF with PCSrcE: a redirect is taken even while stalled.
REQ-020 SHALL compute PCF+4 modulo 2^XLEN: all-ones minus 3 wraps to 0, with no flag.
REQ-021 SHALL load PCTargetE and the predicted target unmodified; the low two bits are not masked.
REQ-022 SHALL perform the BTB update when UpdE=1 on a hit of UpdPCE (tag match):
- counter increments (saturating at 2'b11) if UpdTakenE=1, otherwise decrements (saturating at 2'b00);
- target is overwritten with UpdTargetE when UpdTakenE=1.
REQ-023 SHALL perform the BTB update when UpdE=1 on a miss:
- if UpdTakenE=1, the entry is allocated or replaced with valid=1, new tag, UpdTargetE, counter=2'b10;
- if UpdTakenE=0, there is no write.
REQ-024 SHALL make a BTB write take effect at the clock edge: a same-cycle lookup of the written index sees the old contents, with no bypass.
REQ-025 SHALL apply the BTB update independently of StallF and PCSrcE.
REQ-026 SHALL have latency 1: PCF reflects the next-PC choice one edge after inputs are sampled.

Reset
REQ-027 SHALL, when rst=1, immediately (asynchronously) force PCF=RESET_VEC and clear all BTB valid bits.
- PredTakenF=0 and PredTargetF=0 as a consequence.
REQ-028 SHALL leave BTB tag, target and counter fields not reset.
REQ-029 SHALL, on reset assertion mid-operation, discard any concurrent PCSrcE or UpdE.
REQ-030 SHALL, on the first edge after rst deasserts, resume normal priority from RESET_VEC.

Structure
REQ-031 SHALL place in a shared package: the default XLEN, the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the allocate-counter constant.
REQ-032 SHALL contain one sub-module, btb (storage, lookup, update), instantiated inside pc_predict_gen; the next-PC mux and the PCF register stay at top level.

Verification
REQ-033 SHALL cover scenario 1: rst pulse mid-run with PCF=0x40 -> PCF=0x0 immediately; after release, PCF advances 0x4, 0x8, ...
REQ-034 SHALL cover scenario 2: UpdE with UpdPCE=0x10, UpdTargetE=0x80, UpdTakenE=1; later PCF reaches 0x10 -> PredTakenF=1, next PCF=0x80.
REQ-035 SHALL cover scenario 3: the scenario-2 entry, then two not-taken updates for 0x10 -> counter goes 10->01->00; fetch at 0x10 gives PredTakenF=0, next PCF=0x14.
REQ-036 SHALL cover scenario 4: StallF=1 and PCSrcE=1, PCTargetE=0x200 in the same cycle -> next PCF=0x200.
REQ-037 SHALL cover scenario 5: with BTB_DEPTH=16, allocate 0x10 then 0x50 (same index, different tag) -> fetch at 0x10 misses, fetch at 0x50 predicts.
REQ-038 SHALL cover scenario 6: with XLEN=32, force PCF=0xFFFF_FFFC with no hit -> next PCF=0x0000_0000.
